// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART word serializer.
package uart_pkg;

    localparam int NB_BYTE        = 8;
    localparam int NB_DATA        = 32;
    localparam int NB_TIMEOUT     = 17;
    localparam int TIMEOUT_CYCLES = 100000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Width of a counter that indexes n items, never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_word_serializer.sv
// Splits one latched word into bytes (LSB first) for the UART byte transmitter.
// Optional per-byte watchdog: define UART_WORD_SER_TIMEOUT_EN.
module uart_word_serializer #(
    parameter int NB_DATA = uart_pkg::NB_DATA,
    parameter int NB_BYTE = uart_pkg::NB_BYTE
`ifdef UART_WORD_SER_TIMEOUT_EN
    ,
    parameter int NB_TIMEOUT     = uart_pkg::NB_TIMEOUT,
    parameter int TIMEOUT_CYCLES = uart_pkg::TIMEOUT_CYCLES
`endif
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tx_start_32b,
    input  logic [NB_DATA-1:0] i_tx_data,
    input  logic               i_byte_done,
    output logic [NB_BYTE-1:0] o_byte,
    output logic               o_byte_start,
    output logic               o_tx_done_32b_pulse,
    output logic               o_busy,
    output logic               o_error
);

    import uart_pkg::state_t;
    import uart_pkg::IDLE;
    import uart_pkg::SEND;
    import uart_pkg::WAIT;
    import uart_pkg::DONE;
    import uart_pkg::idx_width;

    localparam int N_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_IDX  = idx_width(N_BYTES);
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_BYTES - 1);

    state_t              state_q;
    state_t              state_d;
    logic [NB_DATA-1:0]  word_q;
    logic [NB_IDX-1:0]   idx_q;
    logic [NB_IDX-1:0]   idx_next;
    logic [NB_BYTE-1:0]  byte_q;
    logic                accept;
    logic                advance;
    logic                timeout;

    assign accept   = (state_q == IDLE) && i_tx_start_32b;
    assign advance  = (state_q == WAIT) && i_byte_done && (idx_q != LAST_IDX);
    assign idx_next = idx_q + NB_IDX'(1);

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_tx_start_32b) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (i_byte_done) begin
                    state_d = (idx_q == LAST_IDX) ? DONE : SEND;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Output decode (Moore: outputs depend on the registered state only)
    // ---------------------------------------------------------------
    always_comb begin
        o_byte_start        = 1'b0;
        o_tx_done_32b_pulse = 1'b0;
        o_busy              = 1'b0;
        unique case (state_q)
            IDLE: begin
                o_busy = 1'b0;
            end
            SEND: begin
                o_byte_start = 1'b1;
                o_busy       = 1'b1;
            end
            WAIT: begin
                o_busy = 1'b1;
            end
            DONE: begin
                o_tx_done_32b_pulse = 1'b1;
                o_busy              = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Word, index and presented byte
    // ---------------------------------------------------------------
    // The byte is loaded on the edge that enters SEND, so it is already
    // valid in the start cycle and holds through WAIT and afterwards in IDLE.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            // NOTE: the word register is a plain register, not a memory, so it
            // is cleared with the rest of the state.
            word_q <= '0;
            idx_q  <= '0;
            byte_q <= '0;
        end else if (accept) begin
            word_q <= i_tx_data;
            idx_q  <= '0;
            byte_q <= i_tx_data[NB_BYTE-1:0];
        end else if (advance) begin
            idx_q  <= idx_next;
            byte_q <= word_q[NB_BYTE*int'(idx_next) +: NB_BYTE];
        end
    end

    assign o_byte = byte_q;

    // ---------------------------------------------------------------
    // Per-byte watchdog
    // ---------------------------------------------------------------
`ifdef UART_WORD_SER_TIMEOUT_EN
    localparam logic [NB_TIMEOUT-1:0] WD_LIMIT = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    logic [NB_TIMEOUT-1:0] wd_q;
    logic                  error_q;

    // A done pulse on the limit cycle wins over the abort.
    assign timeout = (state_q == WAIT) && !i_byte_done && (wd_q == WD_LIMIT);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            error_q <= timeout;
            if (state_q == WAIT) begin
                wd_q <= wd_q + NB_TIMEOUT'(1);
            end else begin
                wd_q <= '0;
            end
        end
    end

    assign o_error = error_q;
`else
    assign timeout = 1'b0;
    assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_word_serializer.sv
// Self-checking bench for uart_word_serializer: a byte-transmitter responder plus
// a word-level reference model (bytes = arithmetic slices of the word, LSB first).
module tb_uart_word_serializer;

    localparam int NB_DATA   = 32;
    localparam int NB_BYTE   = 8;
    localparam int N_BYTES   = NB_DATA / NB_BYTE;
    localparam int TO_CYCLES = 16;

    logic               i_clock        = 1'b0;
    logic               i_reset        = 1'b0;
    logic               i_tx_start_32b = 1'b0;
    logic [NB_DATA-1:0] i_tx_data      = '0;
    logic               i_byte_done;
    logic [NB_BYTE-1:0] o_byte;
    logic               o_byte_start;
    logic               o_tx_done_32b_pulse;
    logic               o_busy;
    logic               o_error;

    logic resp_done   = 1'b0;
    logic manual_done = 1'b0;
    assign i_byte_done = resp_done | manual_done;

`ifdef UART_WORD_SER_TIMEOUT_EN
    uart_word_serializer #(
        .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE),
        .NB_TIMEOUT(17), .TIMEOUT_CYCLES(TO_CYCLES)
    ) dut (
`else
    uart_word_serializer #(
        .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE)
    ) dut (
`endif
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_tx_start_32b(i_tx_start_32b),
        .i_tx_data(i_tx_data),
        .i_byte_done(i_byte_done),
        .o_byte(o_byte),
        .o_byte_start(o_byte_start),
        .o_tx_done_32b_pulse(o_tx_done_32b_pulse),
        .o_busy(o_busy),
        .o_error(o_error)
    );

    always #5 i_clock = ~i_clock;

    int n_cmp = 0;
    int n_err = 0;

    // Observation and byte-transmitter responder, evaluated on the falling edge.
    int                 cyc = 0;
    logic [NB_BYTE-1:0] obs_bytes[$];
    int                 start_cyc[$];
    int                 done_cyc[$];
    int                 err_cyc[$];
    int                 resp_cyc[$];
    bit                 resp_en    = 1'b0;
    int                 resp_delay = 5;
    int                 resp_cnt   = 0;

    always @(negedge i_clock) begin
        cyc++;
        resp_done = 1'b0;
        if (resp_en && resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                resp_done = 1'b1;
                resp_cyc.push_back(cyc);
            end
        end
        if (o_byte_start) begin
            obs_bytes.push_back(o_byte);
            start_cyc.push_back(cyc);
            if (resp_en) resp_cnt = resp_delay;
        end
        if (o_tx_done_32b_pulse) done_cyc.push_back(cyc);
        if (o_error) err_cyc.push_back(cyc);
    end

    task automatic tick();
        @(negedge i_clock);
        #1;
    endtask

    task automatic clear_obs();
        obs_bytes.delete();
        start_cyc.delete();
        done_cyc.delete();
        err_cyc.delete();
        resp_cyc.delete();
        resp_cnt = 0;
    endtask

    function automatic logic [NB_BYTE-1:0] model_byte(input logic [NB_DATA-1:0] w, input int i);
        return NB_BYTE'((w >> (NB_BYTE * i)) & 32'hFF);
    endfunction

    // Compare the recorded byte stream against the model for word w.
    task automatic check_bytes(input logic [NB_DATA-1:0] w, input string tag);
        n_cmp++;
        if (obs_bytes.size() !== N_BYTES) begin
            n_err++;
            $display("FAIL %s byte_count: got %0d expected %0d", tag, obs_bytes.size(), N_BYTES);
        end
        for (int i = 0; i < N_BYTES; i++) begin
            if (i < obs_bytes.size()) begin
                n_cmp++;
                if (obs_bytes[i] !== model_byte(w, i)) begin
                    n_err++;
                    $display("FAIL %s byte%0d: got %h expected %h", tag, i, obs_bytes[i], model_byte(w, i));
                end
            end
        end
    endtask

    // Send one word with the responder answering 'delay' cycles after each start.
    task automatic run_word(input logic [NB_DATA-1:0] w, input int delay, input bit spur_send,
                            input string tag);
        int budget;
        int t0;
        clear_obs();
        resp_delay = delay;
        resp_en    = 1'b1;
        tick();
        i_tx_start_32b = 1'b1;
        i_tx_data      = w;
        t0             = cyc;
        tick();
        i_tx_start_32b = 1'b0;
        i_tx_data      = $urandom();
        budget         = 0;
        while (done_cyc.size() == 0 && budget < 400) begin
            manual_done = spur_send && o_byte_start;
            tick();
            budget++;
        end
        manual_done = 1'b0;

        n_cmp++;
        if (budget >= 400) begin
            n_err++;
            $display("FAIL %s done_timeout: got no done pulse within %0d cycles", tag, budget);
        end
        check_bytes(w, tag);
        n_cmp++;
        if (start_cyc.size() == 0 || start_cyc[0] !== t0 + 1) begin
            n_err++;
            $display("FAIL %s first_start_latency: got cycle %0d expected %0d", tag,
                     (start_cyc.size() > 0) ? start_cyc[0] : -1, t0 + 1);
        end
        for (int i = 0; i + 1 < start_cyc.size() && i < resp_cyc.size(); i++) begin
            n_cmp++;
            if (start_cyc[i+1] !== resp_cyc[i] + 1) begin
                n_err++;
                $display("FAIL %s restart_latency%0d: got cycle %0d expected %0d", tag, i,
                         start_cyc[i+1], resp_cyc[i] + 1);
            end
        end
        if (done_cyc.size() > 0 && resp_cyc.size() > 0) begin
            n_cmp++;
            if (done_cyc[0] !== resp_cyc[resp_cyc.size()-1] + 1) begin
                n_err++;
                $display("FAIL %s done_latency: got cycle %0d expected %0d", tag, done_cyc[0],
                         resp_cyc[resp_cyc.size()-1] + 1);
            end
        end
        n_cmp++;
        if (o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy_in_done: got %b expected 1", tag, o_busy);
        end
        tick();
        n_cmp++;
        if (o_busy !== 1'b0 || done_cyc.size() !== 1) begin
            n_err++;
            $display("FAIL %s after_done: got busy=%b dones=%0d expected busy=0 dones=1", tag,
                     o_busy, done_cyc.size());
        end
        n_cmp++;
        if (o_byte !== model_byte(w, N_BYTES - 1)) begin
            n_err++;
            $display("FAIL %s byte_hold: got %h expected %h", tag, o_byte, model_byte(w, N_BYTES - 1));
        end
        resp_en = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        i_reset        = 1'b0;
        i_tx_start_32b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_tx_data   = $urandom();
            manual_done = i[0];
            tick();
            if ({o_byte, o_byte_start, o_tx_done_32b_pulse, o_busy, o_error} !== '0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL reset_outputs: got %0d nonzero cycles expected 0", bad);
        end
        i_tx_start_32b = 1'b0;
        manual_done    = 1'b0;
        clear_obs();
        i_reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (o_busy !== 1'b0 || start_cyc.size() !== 0) begin
            n_err++;
            $display("FAIL reset_release_idle: got busy=%b starts=%0d expected busy=0 starts=0",
                     o_busy, start_cyc.size());
        end
    endtask

    task automatic test_basic();
        run_word(32'hDEADBEEF, 5, 1'b0, "basic_deadbeef");
    endtask

    task automatic test_ignored_starts();
        int  budget;
        bit  injected;
        clear_obs();
        resp_delay = 5;
        resp_en    = 1'b1;
        tick();
        i_tx_start_32b = 1'b1;
        i_tx_data      = 32'hDEADBEEF;
        tick();
        i_tx_start_32b = 1'b0;
        injected       = 1'b0;
        budget         = 0;
        while (done_cyc.size() == 0 && budget < 400) begin
            if (!injected && obs_bytes.size() == 2 && o_busy && !o_byte_start) begin
                i_tx_start_32b = 1'b1;
                i_tx_data      = 32'h12345678;
                injected       = 1'b1;
            end else begin
                i_tx_start_32b = 1'b0;
            end
            tick();
            budget++;
        end
        // This tick sits in DONE: a start here must be dropped.
        i_tx_start_32b = 1'b1;
        i_tx_data      = 32'h12345678;
        tick();
        i_tx_start_32b = 1'b0;
        n_cmp++;
        if (budget >= 400) begin
            n_err++;
            $display("FAIL ignore_done_timeout: got no done pulse within %0d cycles", budget);
        end
        check_bytes(32'hDEADBEEF, "ignore_first_word");
        n_cmp++;
        if (o_busy !== 1'b0 || done_cyc.size() !== 1) begin
            n_err++;
            $display("FAIL ignore_start_in_done: got busy=%b dones=%0d expected busy=0 dones=1",
                     o_busy, done_cyc.size());
        end
        resp_en = 1'b0;
        run_word(32'h12345678, 5, 1'b0, "after_ignore_12345678");
    endtask

    task automatic test_spurious_done();
        int bad;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            manual_done = 1'b1;
            tick();
            manual_done = 1'b0;
            tick();
            if (o_busy !== 1'b0 || o_byte_start !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL idle_spurious_done: got %0d active cycles expected 0", bad);
        end
        run_word($urandom(), 3, 1'b1, "spurious_in_send");
    endtask

    task automatic test_reset_mid_word();
        int budget;
        clear_obs();
        resp_delay = 3;
        resp_en    = 1'b1;
        tick();
        i_tx_start_32b = 1'b1;
        i_tx_data      = 32'hCAFEF00D;
        tick();
        i_tx_start_32b = 1'b0;
        budget         = 0;
        while (!(obs_bytes.size() == 2 && !o_byte_start) && budget < 200) begin
            tick();
            budget++;
        end
        n_cmp++;
        if (budget >= 200) begin
            n_err++;
            $display("FAIL midreset_reach_wait: got %0d bytes expected 2", obs_bytes.size());
        end
        i_reset = 1'b0;
        #1;
        n_cmp++;
        if ({o_byte, o_byte_start, o_tx_done_32b_pulse, o_busy, o_error} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: got byte=%h start=%b done=%b busy=%b err=%b expected all 0",
                     o_byte, o_byte_start, o_tx_done_32b_pulse, o_busy, o_error);
        end
        resp_en  = 1'b0;
        resp_cnt = 0;
        tick();
        tick();
        i_reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (done_cyc.size() !== 0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_no_done: got dones=%0d busy=%b expected 0 and 0",
                     done_cyc.size(), o_busy);
        end
        run_word(32'hCAFEF00D, 4, 1'b0, "after_reset_cafef00d");
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            run_word($urandom(), int'($urandom_range(1, 8)), bit'($urandom_range(0, 1)),
                     $sformatf("random%0d", k));
        end
    endtask

    task automatic test_watchdog();
        int t0;
        int budget;
        int bad_err;
        int bad_busy;
        clear_obs();
        resp_en = 1'b0;
        tick();
        i_tx_start_32b = 1'b1;
        i_tx_data      = $urandom();
        t0             = cyc;
        tick();
        i_tx_start_32b = 1'b0;
`ifdef UART_WORD_SER_TIMEOUT_EN
        budget = 0;
        while (err_cyc.size() == 0 && budget < 100) begin
            tick();
            budget++;
        end
        // WAIT is entered at t0+2; the abort shows TO_CYCLES cycles later.
        n_cmp++;
        if (err_cyc.size() == 0 || err_cyc[0] !== t0 + 2 + TO_CYCLES) begin
            n_err++;
            $display("FAIL watchdog_error_time: got cycle %0d expected %0d",
                     (err_cyc.size() > 0) ? err_cyc[0] : -1, t0 + 2 + TO_CYCLES);
        end
        n_cmp++;
        if (o_busy !== 1'b0 || done_cyc.size() !== 0) begin
            n_err++;
            $display("FAIL watchdog_abort_idle: got busy=%b dones=%0d expected 0 and 0",
                     o_busy, done_cyc.size());
        end
        tick();
        n_cmp++;
        if (err_cyc.size() !== 1 || o_error !== 1'b0) begin
            n_err++;
            $display("FAIL watchdog_single_pulse: got pulses=%0d err=%b expected 1 and 0",
                     err_cyc.size(), o_error);
        end
        run_word($urandom(), 2, 1'b0, "after_watchdog");
`else
        bad_err  = 0;
        bad_busy = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (o_error !== 1'b0) bad_err++;
            if (o_busy !== 1'b1) bad_busy++;
        end
        n_cmp++;
        if (bad_err !== 0) begin
            n_err++;
            $display("FAIL hang_no_error: got %0d error cycles expected 0", bad_err);
        end
        n_cmp++;
        if (bad_busy !== 0 || obs_bytes.size() !== 1 || done_cyc.size() !== 0) begin
            n_err++;
            $display("FAIL hang_stays_wait: got idle=%0d bytes=%0d dones=%0d expected 0 1 0",
                     bad_busy, obs_bytes.size(), done_cyc.size());
        end
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        tick();
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL hang_reset_recover: got busy=%b expected 0", o_busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignored_starts();
        test_spurious_done();
        test_reset_mid_word();
        test_random();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected finish before %0t", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/uart_word_serializer.md
Name: uart_word_serializer

Overview:
- Sits between the debug unit's 32-bit transmit request and the 8-bit UART transmitter core.
- Latches one 32-bit word and issues it to the byte transmitter as NB_DATA/NB_BYTE bytes, least-significant byte first.
- Waits for the byte transmitter's done pulse after each byte.
- Emits a single-cycle 32-bit-done pulse that the debug unit uses to sequence its next word.

Parameters:
NB_DATA, 32, transmitted word width; must be an integer multiple of NB_BYTE
NB_BYTE, 8, UART byte width
N_BYTES, NB_DATA/NB_BYTE, bytes per word (derived localparam, not overridable)
NB_TIMEOUT, 17, width of the watchdog counter (used only with the optional feature)
TIMEOUT_CYCLES, 100000, cycles allowed per byte before abort (used only with the optional feature)

Ports:
i_clock  in  1  system clock (divided clock domain)
i_reset  in  1  asynchronous, active-low reset
i_tx_start_32b  in  1  single-cycle request to send i_tx_data
i_tx_data  in  NB_DATA  word to send; sampled only in the start cycle
i_byte_done  in  1  single-cycle pulse from the byte transmitter: current byte finished
o_byte  out  NB_BYTE  byte presented to the byte transmitter; stable from o_byte_start until the matching i_byte_done
o_byte_start  out  1  single-cycle start pulse to the byte transmitter
o_tx_done_32b_pulse  out  1  single-cycle pulse: all N_BYTES sent
o_busy  out  1  high from the cycle after acceptance until the return to IDLE
o_error  out  1  single-cycle timeout-abort pulse; tied to 0 when the optional feature is compiled out

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=IDLE; word register and byte index cleared.
  - All outputs 0: o_byte=0, o_byte_start=0, o_tx_done_32b_pulse=0, o_busy=0, o_error=0.
- Reset deassertion mid-word: no partial completion. After reset the state is IDLE and no done pulse is issued.
- States: IDLE, SEND, WAIT, DONE.
- IDLE:
  - On i_tx_start_32b=1: latch i_tx_data, set index=0, go to SEND.
  - i_byte_done is ignored in IDLE.
- SEND (one cycle):
  - o_byte_start=1; o_byte=word[index*NB_BYTE +: NB_BYTE].
  - Go to WAIT.
- WAIT:
  - On i_byte_done=1 with index<N_BYTES-1: index+1, go to SEND. The next start pulse appears the cycle after the done pulse.
  - On i_byte_done=1 with index=N_BYTES-1: go to DONE.
- DONE (one cycle):
  - o_tx_done_32b_pulse=1, o_busy=1.
  - Go to IDLE.
- o_busy timing: 1 in SEND, WAIT and DONE. 0 in IDLE, including the acceptance cycle (combinational view not exported).
- o_byte is registered. It holds the last byte value in IDLE until the next word is loaded.
- Latency: start at cycle t produces the first o_byte_start at t+1. The last i_byte_done at cycle u produces o_tx_done_32b_pulse at u+1 and IDLE at u+2.
- A new i_tx_start_32b in any state other than IDLE, including DONE, is ignored. No queueing.
- i_byte_done in the same cycle as o_byte_start (SEND) is ignored. Only WAIT consumes done pulses.
- The index counter never wraps. It is cleared on acceptance.

Optional Feature:
- Macro: UART_WORD_SER_TIMEOUT_EN.
- Defined:
  - A NB_TIMEOUT-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 without i_byte_done, the block pulses o_error for one cycle, returns directly to IDLE, and emits no o_tx_done_32b_pulse.
  - If i_byte_done arrives in the same cycle the limit is reached, the done pulse wins and there is no error.
- Undefined: no counter is instantiated, o_error is constant 0, and WAIT waits indefinitely.

Decomposition:
- Shared package (uart_pkg): NB_BYTE, NB_DATA, the state encoding (IDLE=2'd0, SEND=2'd1, WAIT=2'd2, DONE=2'd3), and the default TIMEOUT_CYCLES.
- No sub-module is needed. The optional watchdog is a few lines inside the `ifdef`. A separate sub-module is not justified.

Test Plan:
1. Reset held low while asserting i_tx_start_32b -> all outputs stay 0. Release reset -> state IDLE, o_busy=0.
2. Start with i_tx_data=32'hDEADBEEF, byte done returned 5 cycles after each start:
   - o_byte sequence is 8'hEF, 8'hBE, 8'hAD, 8'hDE, with exactly 4 o_byte_start pulses.
   - o_tx_done_32b_pulse occurs once, 1 cycle after the 4th i_byte_done.
   - o_busy falls 1 cycle after that.
3. Second start (32'h12345678) pulsed during WAIT of byte 1 and again during DONE of 32'hDEADBEEF:
   - Both are ignored; only 4 bytes are sent.
   - A start 2 cycles after the done pulse is accepted and sends 8'h78, 8'h56, 8'h34, 8'h12.
4. Spurious i_byte_done in IDLE and in SEND -> no state change; the index does not advance; byte count per word stays 4.
5. Reset asserted in WAIT after byte 2 of 32'hCAFEF00D -> outputs 0 immediately with no done pulse. A fresh start after release sends 8'h0D first.
6. With UART_WORD_SER_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold i_byte_done:
   - o_error pulses once, 16 cycles after entering WAIT; no 32-bit done; back in IDLE.
   - With the macro undefined, the block stays in WAIT for 1000 cycles with o_error=0.
